// File: rtl/acc_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : acc_mem_pkg
//  Purpose  : Shared constants for the accelerator memory server: FSM state
//             encoding, word size, latency limit and the address check helper.
//  Revision : 1.0  initial release
// ============================================================================
package acc_mem_pkg;

  // FSM state encoding
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_RD_HOLD = 3'd2;
  localparam logic [2:0] S_WR_WAIT = 3'd3;
  localparam logic [2:0] S_WR_HOLD = 3'd4;

  localparam int WORD_BYTES  = 4;
  localparam int LATENCY_MAX = 15;

  // True when a byte address is misaligned or lies beyond the RAM depth
  function automatic logic addr_is_bad(input logic [63:0] addr, input int unsigned addr_wid);
    logic [63:0] hi;
    hi = addr >> (addr_wid + 32'd2);
    return (hi != 64'd0) || (addr[1:0] != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_mem_server_if.sv
`default_nettype none
// ============================================================================
//  Module   : acc_mem_server_if
//  Purpose  : Word-serial read/write handshake between the ADPCM accelerator
//             wrapper (master) and the memory server (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface acc_mem_server_if #(
  parameter int DATA_WID = 32
);
  logic                read_enable;
  logic                finish_read;
  logic [63:0]         read_addr;
  logic [63:0]         read_size;
  logic [63:0]         read_ready;
  logic [DATA_WID-1:0] read_data;

  logic                write_enable;
  logic                finish_write;
  logic [63:0]         write_addr;
  logic [63:0]         write_size;
  logic [DATA_WID-1:0] write_data;
  logic [63:0]         write_ready;

  logic                acc_done;

  modport master (
    output read_enable, finish_read, read_addr, read_size,
    input  read_ready, read_data,
    output write_enable, finish_write, write_addr, write_size, write_data,
    input  write_ready,
    output acc_done
  );

  modport slave (
    input  read_enable, finish_read, read_addr, read_size,
    output read_ready, read_data,
    input  write_enable, finish_write, write_addr, write_size, write_data,
    output write_ready,
    input  acc_done
  );
endinterface
`default_nettype wire

// File: rtl/acc_word_ram.sv
`default_nettype none
// ============================================================================
//  Module   : acc_word_ram
//  Purpose  : Dual-port word RAM. Port A serves the accelerator FSM (read with
//             enable, write), port B serves the host (write plus registered
//             read every cycle). Array contents are not reset.
//  Revision : 1.0  initial release
// ============================================================================
module acc_word_ram #(
  parameter int ADDR_WID = 7,
  parameter int DATA_WID = 32
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                i_a_re,
  input  wire logic                i_a_we,
  input  wire logic [ADDR_WID-1:0] i_a_addr,
  input  wire logic [DATA_WID-1:0] i_a_wdata,
  output logic      [DATA_WID-1:0] o_a_rdata,
  input  wire logic                i_b_we,
  input  wire logic [ADDR_WID-1:0] i_b_addr,
  input  wire logic [DATA_WID-1:0] i_b_wdata,
  output logic      [DATA_WID-1:0] o_b_rdata
);

  logic [DATA_WID-1:0] r_mem [0:(2**ADDR_WID)-1];
  logic [DATA_WID-1:0] r_a_rdata;
  logic [DATA_WID-1:0] r_b_rdata;

  // Array writes; the server never lets both ports write in the same cycle
  always_ff @(posedge clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_wdata;
    if (i_b_we) r_mem[i_b_addr] <= i_b_wdata;
  end

  // Port A registered read, only updated when the FSM asks for a word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_a_rdata <= '0;
    else if (i_a_re) r_a_rdata <= r_mem[i_a_addr];
  end

  // Port B registered read, free-running so host_rdata always tracks host_addr
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_b_rdata <= '0;
    else        r_b_rdata <= r_mem[i_b_addr];
  end

  assign o_a_rdata = r_a_rdata;
  assign o_b_rdata = r_b_rdata;

endmodule
`default_nettype wire

// File: rtl/acc_mem_server.sv
`default_nettype none
// ============================================================================
//  Module   : acc_mem_server
//  Purpose  : Memory-side responder for the ADPCM accelerator wrapper. Answers
//             word-serial read/write handshakes from a local RAM after a fixed
//             latency; the host preloads and reads back through a side port.
//  Revision : 1.0  initial release
// ============================================================================
module acc_mem_server
  import acc_mem_pkg::*;
#(
  parameter int ADDR_WID = 7,
  parameter int DATA_WID = 32,
  parameter int LATENCY  = 2
) (
  input  wire logic                clk,
  input  wire logic                reset,
  acc_mem_server_if.slave          acc,
  input  wire logic                host_we,
  input  wire logic [ADDR_WID-1:0] host_addr,
  input  wire logic [DATA_WID-1:0] host_wdata,
  output logic      [DATA_WID-1:0] host_rdata,
  input  wire logic                clear,
  output logic                     busy,
  output logic                     err,
  output logic                     done_seen,
  output logic      [31:0]         rd_count,
  output logic      [31:0]         wr_count
);

  // Latency is clamped to the supported 1..15 range
  localparam int         c_LAT      = (LATENCY < 1) ? 1 :
                                      (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [3:0] c_LAT_LOAD = 4'(c_LAT - 1);
  localparam logic [63:0] c_SIZE    = 64'(WORD_BYTES);

  logic [2:0]          r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_WID-1:0] r_idx;
  logic [DATA_WID-1:0] r_wdata;
  logic                r_oob;
  logic                r_rd_zero;
  logic                r_read_ready;
  logic                r_write_ready;
  logic                r_err;
  logic                r_done_seen;
  logic [31:0]         r_rd_count;
  logic [31:0]         r_wr_count;

  logic                w_idle;
  logic                w_rd_bad;
  logic                w_wr_bad;
  logic                w_rd_fire;
  logic                w_wr_fire;
  logic                w_host_ok;
  logic                w_set_err;
  logic [DATA_WID-1:0] w_a_rdata;

  assign w_idle    = (r_state == S_IDLE);
  assign w_rd_bad  = addr_is_bad(acc.read_addr,  ADDR_WID);
  assign w_wr_bad  = addr_is_bad(acc.write_addr, ADDR_WID);
  assign w_rd_fire = (r_state == S_RD_WAIT) && (r_cnt == 4'd0);
  assign w_wr_fire = (r_state == S_WR_WAIT) && (r_cnt == 4'd0);
  assign w_host_ok = w_idle && !acc.read_enable && !acc.write_enable;

  // Error sources: bad read (address/size/both enables), bad write, refused host write
  always_comb begin
    w_set_err = 1'b0;
    if (w_idle && acc.read_enable) begin
      if (w_rd_bad || (acc.read_size != c_SIZE) || acc.write_enable) w_set_err = 1'b1;
    end else if (w_idle && acc.write_enable) begin
      if (w_wr_bad || (acc.write_size != c_SIZE)) w_set_err = 1'b1;
    end
    if (host_we && !w_host_ok) w_set_err = 1'b1;
  end

  // Request FSM: accept, count down latency, present response, hold until released
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_idx         <= '0;
      r_wdata       <= '0;
      r_oob         <= 1'b0;
      r_rd_zero     <= 1'b0;
      r_read_ready  <= 1'b0;
      r_write_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (acc.read_enable) begin
            r_idx   <= acc.read_addr[ADDR_WID+1:2];
            r_oob   <= w_rd_bad;
            r_cnt   <= c_LAT_LOAD;
            r_state <= S_RD_WAIT;
          end else if (acc.write_enable) begin
            r_idx   <= acc.write_addr[ADDR_WID+1:2];
            r_wdata <= acc.write_data;
            r_oob   <= w_wr_bad;
            r_cnt   <= c_LAT_LOAD;
            r_state <= S_WR_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_read_ready <= 1'b1;
            r_rd_zero    <= r_oob;
            r_state      <= S_RD_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RD_HOLD: begin
          if (acc.finish_read || !acc.read_enable) begin
            r_read_ready <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        S_WR_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_write_ready <= 1'b1;
            r_state       <= S_WR_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_WR_HOLD: begin
          if (acc.finish_write || !acc.write_enable) begin
            r_write_ready <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky flags and word counters; clear overrides any set or increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err       <= 1'b0;
      r_done_seen <= 1'b0;
      r_rd_count  <= 32'd0;
      r_wr_count  <= 32'd0;
    end else if (clear) begin
      r_err       <= 1'b0;
      r_done_seen <= 1'b0;
      r_rd_count  <= 32'd0;
      r_wr_count  <= 32'd0;
    end else begin
      if (w_set_err)    r_err       <= 1'b1;
      if (acc.acc_done) r_done_seen <= 1'b1;
      if (w_rd_fire)    r_rd_count  <= r_rd_count + 32'd1;
      if (w_wr_fire)    r_wr_count  <= r_wr_count + 32'd1;
    end
  end

  acc_word_ram #(
    .ADDR_WID (ADDR_WID),
    .DATA_WID (DATA_WID)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .i_a_re    (w_rd_fire),
    .i_a_we    (w_wr_fire && !r_oob),
    .i_a_addr  (r_idx),
    .i_a_wdata (r_wdata),
    .o_a_rdata (w_a_rdata),
    .i_b_we    (host_we && w_host_ok),
    .i_b_addr  (host_addr),
    .i_b_wdata (host_wdata),
    .o_b_rdata (host_rdata)
  );

  // Out-of-range reads present zero instead of whatever the RAM returned
  assign acc.read_data   = r_rd_zero ? '0 : w_a_rdata;
  assign acc.read_ready  = {63'd0, r_read_ready};
  assign acc.write_ready = {63'd0, r_write_ready};
  assign busy            = !w_idle;
  assign err             = r_err;
  assign done_seen       = r_done_seen;
  assign rd_count        = r_rd_count;
  assign wr_count        = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_acc_mem_server.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_mem_server
//  Purpose  : Self-checking bench for acc_mem_server. Stimulus pushes expected
//             read words / response cycles into queues; a monitor pops them
//             whenever read_ready or write_ready rises.
//  Revision : 1.0  initial release
// ============================================================================
module tb_acc_mem_server;
  import acc_mem_pkg::*;

  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int LAT = 2;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rd_exp_t;

  logic          clk;
  logic          reset;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          clear;
  logic          busy;
  logic          err;
  logic          done_seen;
  logic [31:0]   rd_count;
  logic [31:0]   wr_count;

  int      cyc;
  int      n_vec;
  int      n_bad;
  rd_exp_t exp_rd[$];
  int      exp_wr[$];
  rd_exp_t mon_e;
  int      mon_w;
  logic    prev_rr;
  logic    prev_wr;

  acc_mem_server_if #(.DATA_WID(DW)) acc ();

  acc_mem_server #(.ADDR_WID(AW), .DATA_WID(DW), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .acc        (acc),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .clear      (clear),
    .busy       (busy),
    .err        (err),
    .done_seen  (done_seen),
    .rd_count   (rd_count),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic host_write(input int idx, input logic [31:0] data);
    host_we    = 1'b1;
    host_addr  = AW'(idx);
    host_wdata = data;
    @(negedge clk);
    host_we    = 1'b0;
  endtask

  task automatic host_check(input string name, input int idx, input logic [31:0] exp);
    host_addr = AW'(idx);
    @(negedge clk);
    check(name, 64'(host_rdata), 64'(exp));
  endtask

  task automatic wait_rr(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 24 && !seen; k++) begin
      @(negedge clk);
      seen = acc.read_ready[0];
    end
    if (!seen) check(name, 64'd0, 64'd1);
  endtask

  task automatic wait_wr(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 24 && !seen; k++) begin
      @(negedge clk);
      seen = acc.write_ready[0];
    end
    if (!seen) check(name, 64'd0, 64'd1);
  endtask

  // Called at a negedge with the server idle (or about to be idle on the next edge)
  task automatic read_word(input logic [63:0] addr, input logic [63:0] size,
                           input logic [31:0] exp, input logic last);
    acc.read_enable = 1'b1;
    acc.read_addr   = addr;
    acc.read_size   = size;
    exp_rd.push_back('{exp, cyc + 1 + LAT});
    wait_rr("rd_timeout");
    if (last) begin
      acc.read_enable = 1'b0;
      @(negedge clk);
    end else begin
      acc.finish_read = 1'b1;
      acc.read_addr   = addr + 64'd4;
      @(negedge clk);
      acc.finish_read = 1'b0;
    end
  endtask

  task automatic write_word(input logic [63:0] addr, input logic [31:0] data, input logic last);
    acc.write_enable = 1'b1;
    acc.write_addr   = addr;
    acc.write_size   = 64'd4;
    acc.write_data   = data;
    exp_wr.push_back(cyc + 1 + LAT);
    wait_wr("wr_timeout");
    if (last) begin
      acc.write_enable = 1'b0;
      @(negedge clk);
    end else begin
      acc.finish_write = 1'b1;
      acc.write_addr   = addr + 64'd4;
      @(negedge clk);
      acc.finish_write = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    cyc = 0; n_vec = 0; n_bad = 0;
    prev_rr = 1'b0; prev_wr = 1'b0;
    reset = 1'b0; clear = 1'b0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    acc.read_enable = 1'b0;  acc.finish_read = 1'b0;
    acc.read_addr = 64'd0;   acc.read_size = 64'd4;
    acc.write_enable = 1'b0; acc.finish_write = 1'b0;
    acc.write_addr = 64'd0;  acc.write_size = 64'd4; acc.write_data = '0;
    acc.acc_done = 1'b0;

    // Scoreboard monitor: compares each rising response against the queue head
    fork
      forever begin
        @(negedge clk);
        if (acc.read_ready[0] && !prev_rr) begin
          if (exp_rd.size() == 0) begin
            check("rd_unexpected", 64'd1, 64'd0);
          end else begin
            mon_e = exp_rd.pop_front();
            check("rd_data", 64'(acc.read_data), 64'(mon_e.data));
            check("rd_rise_cycle", 64'(cyc), 64'(mon_e.cyc));
            check("rd_ready_value", acc.read_ready, 64'd1);
          end
        end
        if (acc.write_ready[0] && !prev_wr) begin
          if (exp_wr.size() == 0) begin
            check("wr_unexpected", 64'd1, 64'd0);
          end else begin
            mon_w = exp_wr.pop_front();
            check("wr_rise_cycle", 64'(cyc), 64'(mon_w));
            check("wr_ready_value", acc.write_ready, 64'd1);
          end
        end
        prev_rr = acc.read_ready[0];
        prev_wr = acc.write_ready[0];
      end
    join_none

    // Reset state
    #1;
    check("rst_read_ready", acc.read_ready, 64'd0);
    check("rst_write_ready", acc.write_ready, 64'd0);
    check("rst_read_data", 64'(acc.read_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_done_seen", 64'(done_seen), 64'd0);
    check("rst_rd_count", 64'(rd_count), 64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    check("rst_host_rdata", 64'(host_rdata), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1: preload and 4-word read burst
    for (int i = 0; i < 4; i++) host_write(i, 32'(i + 1));
    read_word(64'h0, 64'd4, 32'd1, 1'b0);
    read_word(64'h4, 64'd4, 32'd2, 1'b0);
    read_word(64'h8, 64'd4, 32'd3, 1'b0);
    read_word(64'hC, 64'd4, 32'd4, 1'b1);
    check("t1_rd_count", 64'(rd_count), 64'd4);
    check("t1_err", 64'(err), 64'd0);
    check("t1_busy_after", 64'(busy), 64'd0);

    // 2: 3-word write burst at 0x40, host readback
    write_word(64'h40, 32'hA, 1'b0);
    write_word(64'h44, 32'hB, 1'b0);
    write_word(64'h48, 32'hC, 1'b1);
    check("t2_wr_count", 64'(wr_count), 64'd3);
    check("t2_err", 64'(err), 64'd0);
    host_check("t2_host_16", 16, 32'hA);
    host_check("t2_host_17", 17, 32'hB);
    host_check("t2_host_18", 18, 32'hC);

    // 3: out-of-range read, clear, then bad size still served
    read_word(64'h200, 64'd4, 32'd0, 1'b1);
    check("t3_oob_err", 64'(err), 64'd1);
    pulse_clear();
    check("t3_clear_err", 64'(err), 64'd0);
    check("t3_clear_rd_count", 64'(rd_count), 64'd0);
    check("t3_clear_wr_count", 64'(wr_count), 64'd0);
    read_word(64'h4, 64'd8, 32'd2, 1'b1);
    check("t3_size_err", 64'(err), 64'd1);
    pulse_clear();

    // 4: host write during S_RD_HOLD is refused
    acc.read_enable = 1'b1;
    acc.read_addr   = 64'h0;
    acc.read_size   = 64'd4;
    exp_rd.push_back('{32'd1, cyc + 1 + LAT});
    wait_rr("t4_rd_timeout");
    host_we = 1'b1; host_addr = AW'(2); host_wdata = 32'hDEAD;
    @(negedge clk);
    host_we = 1'b0;
    acc.read_enable = 1'b0;
    @(negedge clk);
    check("t4_hold_host_err", 64'(err), 64'd1);
    host_check("t4_ram2_unchanged", 2, 32'd3);
    pulse_clear();
    // 4b: both enables high in S_IDLE, read wins
    acc.read_enable  = 1'b1;
    acc.read_addr    = 64'h4;
    acc.write_enable = 1'b1;
    acc.write_addr   = 64'h8;
    acc.write_data   = 32'h55;
    exp_rd.push_back('{32'd2, cyc + 1 + LAT});
    wait_rr("t4b_rd_timeout");
    acc.read_enable  = 1'b0;
    acc.write_enable = 1'b0;
    @(negedge clk);
    check("t4b_both_err", 64'(err), 64'd1);
    check("t4b_wr_count", 64'(wr_count), 64'd0);
    check("t4b_rd_count", 64'(rd_count), 64'd1);
    host_check("t4b_ram2_unwritten", 2, 32'd3);
    pulse_clear();

    // 5: asynchronous reset while in S_RD_WAIT
    acc.read_enable = 1'b1;
    acc.read_addr   = 64'h0;
    @(posedge clk);
    #1;
    check("t5_busy_in_wait", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("t5_reset_read_ready", acc.read_ready, 64'd0);
    check("t5_reset_busy", 64'(busy), 64'd0);
    acc.read_enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    host_check("t5_ram0_intact", 0, 32'd1);

    // 6: acc_done against clear
    acc.acc_done = 1'b1;
    clear        = 1'b1;
    @(negedge clk);
    acc.acc_done = 1'b0;
    clear        = 1'b0;
    check("t6_done_with_clear", 64'(done_seen), 64'd0);
    acc.acc_done = 1'b1;
    @(negedge clk);
    acc.acc_done = 1'b0;
    check("t6_done_alone", 64'(done_seen), 64'd1);

    repeat (3) @(negedge clk);
    check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
